// File: rtl/clock_group_pkg.sv
// Shared types and elaboration helpers for clock-group reset sequencers.
package clock_group_pkg;

  typedef enum logic [1:0] {
    StHold,
    StSeq,
    StRun,
    StPulse
  } seq_state_e;

  // Counter must hold max(stagger, pulse) - 1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned stagger,
                                            input int unsigned pulse);
    int unsigned m;
    m = (stagger > pulse) ? stagger : pulse;
    return ($clog2(m) > 0) ? $clog2(m) : 1;
  endfunction

  function automatic bit params_legal(input int unsigned n_members,
                                      input int unsigned sync_stages,
                                      input int unsigned stagger,
                                      input int unsigned pulse);
    return (n_members >= 1) && (n_members <= 16) && (sync_stages >= 2) &&
           (stagger >= 2) && (pulse >= 1);
  endfunction

endpackage

// File: rtl/reset_sync_async_low.sv
// Active-low reset synchroniser: asynchronous assert, synchronous deassert.
module reset_sync_async_low #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Staggered clock-enable / reset bring-up for a clock group, with per-member
// reset re-pulse requests once the group is running.
module clock_group_reset_sequencer
  import clock_group_pkg::*;
#(
  parameter int unsigned N_MEMBERS      = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned PULSE_CYCLES   = 8,
  parameter int unsigned IDX_W          = (N_MEMBERS > 1) ? $clog2(N_MEMBERS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [N_MEMBERS-1:0] member_clock_en,
  output logic [N_MEMBERS-1:0] member_reset,
  output logic                 all_released,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_W-1:0]     req_member,
  output logic                 req_error
);

  localparam int unsigned CntW = cnt_width(STAGGER_CYCLES, PULSE_CYCLES);
  localparam logic [CntW-1:0] StaggerLoad = CntW'(STAGGER_CYCLES - 1);
  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES - 1);
  localparam logic [IDX_W:0] NumMembers = (IDX_W + 1)'(N_MEMBERS);
  localparam logic [IDX_W:0] LastIdx = (IDX_W + 1)'(N_MEMBERS - 1);
  localparam logic [N_MEMBERS-1:0] One = N_MEMBERS'(1);

  if (!params_legal(N_MEMBERS, SYNC_STAGES, STAGGER_CYCLES, PULSE_CYCLES)) begin : gen_bad_params
    $error("clock_group_reset_sequencer: illegal parameter set");
  end

  logic rst_sync;

  reset_sync_async_low #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clock   (clock),
    .reset   (reset),
    .rst_sync(rst_sync)
  );

  seq_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_MEMBERS-1:0]   en_q, en_d;
  logic [N_MEMBERS-1:0]   mrst_q, mrst_d;
  logic                   err_q, err_d;
  logic                   rel_q, rel_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    en_d    = en_q;
    mrst_d  = mrst_q;
    err_d   = 1'b0;

    case (state_q)
      StHold: begin
        state_d = StSeq;
        idx_d   = '0;
        cnt_d   = StaggerLoad;
        en_d    = en_q | One;
      end
      StSeq: begin
        if (cnt_q == '0) begin
          mrst_d = mrst_q & ~(One << idx_q);
          if ({1'b0, idx_q} < LastIdx) begin
            idx_d = idx_q + 1'b1;
            en_d  = en_q | (One << idx_d);
            cnt_d = StaggerLoad;
          end else begin
            state_d = StRun;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRun: begin
        if (req_valid) begin
          if ({1'b0, req_member} < NumMembers) begin
            mrst_d  = mrst_q | (One << req_member);
            idx_d   = req_member;
            cnt_d   = PulseLoad;
            state_d = StPulse;
          end else begin
            // Out-of-range requests are consumed so the controller never stalls.
            err_d = 1'b1;
          end
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          mrst_d  = mrst_q & ~(One << idx_q);
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StHold;
    endcase

    rel_d = (state_d == StRun);
  end

  // rst_sync is itself cleared asynchronously by reset, so this covers both.
  always_ff @(posedge clock or negedge rst_sync) begin
    if (!rst_sync) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      mrst_q  <= '1;
      err_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      mrst_q  <= mrst_d;
      err_q   <= err_d;
      rel_q   <= rel_d;
    end
  end

  assign member_clock_en = en_q;
  assign member_reset    = mrst_q;
  assign all_released    = rel_q;
  assign req_error       = err_q;
  assign req_ready       = (state_q == StRun);

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Directed bench: three sequencer configurations sharing one clock and group reset.
module tb_clock_group_reset_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // a: defaults (N=4, S=16, P=8)
  logic [3:0] a_en, a_rst;
  logic       a_rel, a_valid, a_ready, a_err;
  logic [1:0] a_member;
  // b: N=3, S=4, P=3
  logic [2:0] b_en, b_rst;
  logic       b_rel, b_valid, b_ready, b_err;
  logic [1:0] b_member;
  // c: N=1, S=2, P=1
  logic [0:0] c_en, c_rst;
  logic       c_rel, c_valid, c_ready, c_err;
  logic [0:0] c_member;

  int n_checks = 0;
  int n_fail   = 0;

  clock_group_reset_sequencer u_a (
    .clock          (clock),
    .reset          (reset),
    .member_clock_en(a_en),
    .member_reset   (a_rst),
    .all_released   (a_rel),
    .req_valid      (a_valid),
    .req_ready      (a_ready),
    .req_member     (a_member),
    .req_error      (a_err)
  );

  clock_group_reset_sequencer #(
    .N_MEMBERS     (3),
    .STAGGER_CYCLES(4),
    .PULSE_CYCLES  (3)
  ) u_b (
    .clock          (clock),
    .reset          (reset),
    .member_clock_en(b_en),
    .member_reset   (b_rst),
    .all_released   (b_rel),
    .req_valid      (b_valid),
    .req_ready      (b_ready),
    .req_member     (b_member),
    .req_error      (b_err)
  );

  clock_group_reset_sequencer #(
    .N_MEMBERS     (1),
    .STAGGER_CYCLES(2),
    .PULSE_CYCLES  (1)
  ) u_c (
    .clock          (clock),
    .reset          (reset),
    .member_clock_en(c_en),
    .member_reset   (c_rst),
    .all_released   (c_rel),
    .req_valid      (c_valid),
    .req_ready      (c_ready),
    .req_member     (c_member),
    .req_error      (c_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Bring-up model: member i enabled from k >= s*i, in reset while k < s*(i+1).
  function automatic logic [31:0] exp_en(input int n, input int s, input int k);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) if (k >= s * i) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] exp_rst(input int n, input int s, input int k);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) if (k < s * (i + 1)) v[i] = 1'b1;
    return v;
  endfunction

  // Caller is positioned just after the SEQ entry edge (k = 0).
  task automatic walk(input int kmax);
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) tick(1);
      check_eq($sformatf("a_en k=%0d", k), 32'(a_en), exp_en(4, 16, k));
      check_eq($sformatf("a_rst k=%0d", k), 32'(a_rst), exp_rst(4, 16, k));
      check_eq($sformatf("a_rel k=%0d", k), 32'(a_rel), 32'(k >= 64));
      check_eq($sformatf("a_ready k=%0d", k), 32'(a_ready), 32'(k >= 64));
      check_eq($sformatf("a_err k=%0d", k), 32'(a_err), 32'd0);
      check_eq($sformatf("b_en k=%0d", k), 32'(b_en), exp_en(3, 4, k));
      check_eq($sformatf("b_rst k=%0d", k), 32'(b_rst), exp_rst(3, 4, k));
      check_eq($sformatf("b_rel k=%0d", k), 32'(b_rel), 32'(k >= 12));
      check_eq($sformatf("c_en k=%0d", k), 32'(c_en), exp_en(1, 2, k));
      check_eq($sformatf("c_rst k=%0d", k), 32'(c_rst), exp_rst(1, 2, k));
      check_eq($sformatf("c_ready k=%0d", k), 32'(c_ready), 32'(k >= 2));
    end
  endtask

  initial begin
    reset    = 1'b0;
    a_valid  = 1'b0;
    a_member = '0;
    b_valid  = 1'b0;
    b_member = '0;
    c_valid  = 1'b0;
    c_member = '0;

    tick(10);
    check_eq("rst a_en", 32'(a_en), 32'h0);
    check_eq("rst a_rst", 32'(a_rst), 32'hF);
    check_eq("rst a_rel", 32'(a_rel), 32'd0);
    check_eq("rst a_ready", 32'(a_ready), 32'd0);
    check_eq("rst a_err", 32'(a_err), 32'd0);
    check_eq("rst b_rst", 32'(b_rst), 32'h7);
    check_eq("rst c_rst", 32'(c_rst), 32'h1);

    // Synchroniser: high after the second edge, SEQ entered on the third.
    reset = 1'b1;
    tick(1);
    check_eq("sync edge1", 32'(u_a.u_reset_sync.rst_sync), 32'd0);
    tick(1);
    check_eq("sync edge2", 32'(u_a.u_reset_sync.rst_sync), 32'd1);
    check_eq("hold edge2 a_en", 32'(a_en), 32'h0);
    tick(1);
    walk(64);

    // a pulses member 2, b gets an out-of-range index, c pulses its only member.
    a_valid  = 1'b1;
    a_member = 2'd2;
    b_valid  = 1'b1;
    b_member = 2'd3;
    c_valid  = 1'b1;
    c_member = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      tick(1);
      if (j == 0) begin
        a_valid = 1'b0;
        b_valid = 1'b0;
        c_valid = 1'b0;
      end
      check_eq($sformatf("pulse a_rst j=%0d", j), 32'(a_rst), (j < 8) ? 32'h4 : 32'h0);
      check_eq($sformatf("pulse a_en j=%0d", j), 32'(a_en), 32'hF);
      check_eq($sformatf("pulse a_ready j=%0d", j), 32'(a_ready), 32'(j >= 8));
      check_eq($sformatf("pulse a_rel j=%0d", j), 32'(a_rel), 32'(j >= 8));
      check_eq($sformatf("oor b_err j=%0d", j), 32'(b_err), 32'(j == 0));
      check_eq($sformatf("oor b_rst j=%0d", j), 32'(b_rst), 32'h0);
      check_eq($sformatf("oor b_ready j=%0d", j), 32'(b_ready), 32'd1);
      check_eq($sformatf("pulse c_rst j=%0d", j), 32'(c_rst), 32'(j < 1));
      check_eq($sformatf("pulse c_ready j=%0d", j), 32'(c_ready), 32'(j >= 1));
    end

    // Restart, then drop reset mid-sequence at SEQ+40.
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);
    walk(40);
    reset = 1'b0;
    #1;
    check_eq("abort a_en", 32'(a_en), 32'h0);
    check_eq("abort a_rst", 32'(a_rst), 32'hF);
    check_eq("abort a_rel", 32'(a_rel), 32'd0);
    check_eq("abort a_ready", 32'(a_ready), 32'd0);
    check_eq("abort b_en", 32'(b_en), 32'h0);
    check_eq("abort c_rst", 32'(c_rst), 32'h1);

    // Request held through the whole sequence is taken on the first RUN cycle.
    a_valid  = 1'b1;
    a_member = 2'd0;
    tick(3);
    reset = 1'b1;
    tick(3);
    walk(64);
    tick(1);
    check_eq("held a_rst", 32'(a_rst), 32'h1);
    check_eq("held a_ready", 32'(a_ready), 32'd0);
    check_eq("held a_rel", 32'(a_rel), 32'd0);
    a_valid = 1'b0;
    tick(7);
    check_eq("held a_rst +7", 32'(a_rst), 32'h1);
    tick(1);
    check_eq("held a_rst +8", 32'(a_rst), 32'h0);
    check_eq("held a_ready +8", 32'(a_ready), 32'd1);
    check_eq("held a_rel +8", 32'(a_rel), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
